// File: rtl/ysyx_22050710_rf_pkg.sv
// rtl/ysyx_22050710_rf_pkg.sv - shared constants for the register-file unit and WS-to-RF bus
package ysyx_22050710_rf_pkg;

    localparam int RF_GPR_ADDR_WD = 5;
    localparam int RF_GPR_WD      = 64;
    localparam int RF_CSR_ADDR_WD = 12;
    localparam int RF_CSR_WD      = 64;
    localparam int RF_GPR_NUM     = 32;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam logic [63:0] MSTATUS_RESET  = 64'h0000_000a_0000_1800;
    localparam logic [63:0] MCAUSE_ECALL_M = 64'd11;

    localparam int MSTATUS_MIE     = 3;
    localparam int MSTATUS_MPIE    = 7;
    localparam int MSTATUS_MPP_LO  = 11;
    localparam int MSTATUS_MPP_HI  = 12;

    // Bus layout, LSB first: csr_wdata, csr_waddr, csr_wen, gpr_wdata, gpr_waddr, gpr_wen
    localparam int WS_CSR_WDATA_LSB = 0;
    localparam int WS_CSR_WADDR_LSB = WS_CSR_WDATA_LSB + RF_CSR_WD;
    localparam int WS_CSR_WEN_POS   = WS_CSR_WADDR_LSB + RF_CSR_ADDR_WD;
    localparam int WS_GPR_WDATA_LSB = WS_CSR_WEN_POS + 1;
    localparam int WS_GPR_WADDR_LSB = WS_GPR_WDATA_LSB + RF_GPR_WD;
    localparam int WS_GPR_WEN_POS   = WS_GPR_WADDR_LSB + RF_GPR_ADDR_WD;
    localparam int WS_TO_RF_BUS_W   = WS_GPR_WEN_POS + 1;

endpackage

// File: rtl/ysyx_22050710_gpr_file.sv
// rtl/ysyx_22050710_gpr_file.sv - 32-entry GPR array, one write port, two bypassed read ports
module ysyx_22050710_gpr_file
    import ysyx_22050710_rf_pkg::*;
#(
    parameter int ADDR_WD = RF_GPR_ADDR_WD,
    parameter int DATA_WD = RF_GPR_WD
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_wen,
    input  logic [ADDR_WD-1:0] i_waddr,
    input  logic [DATA_WD-1:0] i_wdata,
    input  logic [ADDR_WD-1:0] i_raddr1,
    input  logic [ADDR_WD-1:0] i_raddr2,
    output logic [DATA_WD-1:0] o_rdata1,
    output logic [DATA_WD-1:0] o_rdata2
);

    localparam int NREGS = 1 << ADDR_WD;

    logic [DATA_WD-1:0] regs [NREGS];
    logic               wr_live;

    assign wr_live = i_wen && (i_waddr != '0);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_live) begin
            regs[i_waddr] <= i_wdata;
        end
    end

    // Write-through lets decode see a value in the same cycle it is written back
    always_comb begin
        o_rdata1 = '0;
        if (wr_live && (i_waddr == i_raddr1)) begin
            o_rdata1 = i_wdata;
        end else if (i_raddr1 != '0) begin
            o_rdata1 = regs[i_raddr1];
        end
    end

    always_comb begin
        o_rdata2 = '0;
        if (wr_live && (i_waddr == i_raddr2)) begin
            o_rdata2 = i_wdata;
        end else if (i_raddr2 != '0) begin
            o_rdata2 = regs[i_raddr2];
        end
    end

endmodule

// File: rtl/ysyx_22050710_rfu.sv
// rtl/ysyx_22050710_rfu.sv - register-file unit: GPRs, machine CSRs, trap updates
module ysyx_22050710_rfu
    import ysyx_22050710_rf_pkg::*;
#(
    parameter int GPR_ADDR_WD     = RF_GPR_ADDR_WD,
    parameter int GPR_WD          = RF_GPR_WD,
    parameter int CSR_ADDR_WD     = RF_CSR_ADDR_WD,
    parameter int CSR_WD          = RF_CSR_WD,
    parameter int WS_TO_RF_BUS_WD = 2 + GPR_ADDR_WD + GPR_WD + CSR_ADDR_WD + CSR_WD
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [WS_TO_RF_BUS_WD-1:0] i_ws_to_rf_bus,
    input  logic [GPR_ADDR_WD-1:0]     i_raddr1,
    input  logic [GPR_ADDR_WD-1:0]     i_raddr2,
    output logic [GPR_WD-1:0]          o_rdata1,
    output logic [GPR_WD-1:0]          o_rdata2,
    input  logic [CSR_ADDR_WD-1:0]     i_csr_raddr,
    output logic [CSR_WD-1:0]          o_csr_rdata,
    input  logic                       i_ecall,
    input  logic [GPR_WD-1:0]          i_ecall_pc,
    input  logic                       i_mret,
    output logic [CSR_WD-1:0]          o_mtvec,
    output logic [CSR_WD-1:0]          o_mepc
);

    localparam int CSR_WDATA_LSB = 0;
    localparam int CSR_WADDR_LSB = CSR_WDATA_LSB + CSR_WD;
    localparam int CSR_WEN_POS   = CSR_WADDR_LSB + CSR_ADDR_WD;
    localparam int GPR_WDATA_LSB = CSR_WEN_POS + 1;
    localparam int GPR_WADDR_LSB = GPR_WDATA_LSB + GPR_WD;
    localparam int GPR_WEN_POS   = GPR_WADDR_LSB + GPR_ADDR_WD;

    logic                   gpr_wen;
    logic [GPR_ADDR_WD-1:0] gpr_waddr;
    logic [GPR_WD-1:0]      gpr_wdata;
    logic                   csr_wen;
    logic [CSR_ADDR_WD-1:0] csr_waddr;
    logic [CSR_WD-1:0]      csr_wdata;

    assign gpr_wen   = i_ws_to_rf_bus[GPR_WEN_POS];
    assign gpr_waddr = i_ws_to_rf_bus[GPR_WADDR_LSB +: GPR_ADDR_WD];
    assign gpr_wdata = i_ws_to_rf_bus[GPR_WDATA_LSB +: GPR_WD];
    assign csr_wen   = i_ws_to_rf_bus[CSR_WEN_POS];
    assign csr_waddr = i_ws_to_rf_bus[CSR_WADDR_LSB +: CSR_ADDR_WD];
    assign csr_wdata = i_ws_to_rf_bus[CSR_WDATA_LSB +: CSR_WD];

    ysyx_22050710_gpr_file #(
        .ADDR_WD (GPR_ADDR_WD),
        .DATA_WD (GPR_WD)
    ) u_gpr_file (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_wen    (gpr_wen),
        .i_waddr  (gpr_waddr),
        .i_wdata  (gpr_wdata),
        .i_raddr1 (i_raddr1),
        .i_raddr2 (i_raddr2),
        .o_rdata1 (o_rdata1),
        .o_rdata2 (o_rdata2)
    );

    logic [CSR_WD-1:0] mstatus;
    logic [CSR_WD-1:0] mtvec;
    logic [CSR_WD-1:0] mepc;
    logic [CSR_WD-1:0] mcause;
    logic [CSR_WD-1:0] mstatus_trap;

    // Trap result is built from the registered mstatus so bus bits never leak in
    always_comb begin
        mstatus_trap = mstatus;
        if (i_ecall) begin
            mstatus_trap[MSTATUS_MPIE]                  = mstatus[MSTATUS_MIE];
            mstatus_trap[MSTATUS_MIE]                   = 1'b0;
            mstatus_trap[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        end else if (i_mret) begin
            mstatus_trap[MSTATUS_MIE]                   = mstatus[MSTATUS_MPIE];
            mstatus_trap[MSTATUS_MPIE]                  = 1'b1;
            mstatus_trap[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b00;
        end
    end

    // Trap updates are assigned last so they override bus writes to the same CSR
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            mstatus <= CSR_WD'(MSTATUS_RESET);
            mtvec   <= '0;
            mepc    <= '0;
            mcause  <= '0;
        end else begin
            if (csr_wen) begin
                case (csr_waddr)
                    CSR_ADDR_WD'(CSR_MSTATUS): mstatus <= csr_wdata;
                    CSR_ADDR_WD'(CSR_MTVEC):   mtvec   <= csr_wdata;
                    CSR_ADDR_WD'(CSR_MEPC):    mepc    <= csr_wdata;
                    CSR_ADDR_WD'(CSR_MCAUSE):  mcause  <= csr_wdata;
                    default: ;
                endcase
            end
            if (i_ecall) begin
                mepc    <= CSR_WD'(i_ecall_pc);
                mcause  <= CSR_WD'(MCAUSE_ECALL_M);
                mstatus <= mstatus_trap;
            end else if (i_mret) begin
                mstatus <= mstatus_trap;
            end
        end
    end

    always_comb begin
        o_csr_rdata = '0;
        case (i_csr_raddr)
            CSR_ADDR_WD'(CSR_MSTATUS): o_csr_rdata = mstatus;
            CSR_ADDR_WD'(CSR_MTVEC):   o_csr_rdata = mtvec;
            CSR_ADDR_WD'(CSR_MEPC):    o_csr_rdata = mepc;
            CSR_ADDR_WD'(CSR_MCAUSE):  o_csr_rdata = mcause;
            default: ;
        endcase
        // Only an implemented address produced a nonzero read above, so bypass stays within them
        if (csr_wen && (csr_waddr == i_csr_raddr)) begin
            case (i_csr_raddr)
                CSR_ADDR_WD'(CSR_MSTATUS), CSR_ADDR_WD'(CSR_MTVEC),
                CSR_ADDR_WD'(CSR_MEPC), CSR_ADDR_WD'(CSR_MCAUSE): o_csr_rdata = csr_wdata;
                default: ;
            endcase
        end
    end

    assign o_mtvec = mtvec;
    assign o_mepc  = mepc;

endmodule

// File: doc/ysyx_22050710_rfu.md
# ysyx_22050710_rfu

Register-file unit at the receiving end of the write-back stage's WS-to-RF bus. Unpacks the bus, commits GPR and CSR writes at the clock edge, and serves combinational read ports to decode with same-cycle write-through bypass. Also applies hardware trap updates (ecall entry, mret return) to the machine CSRs, so all architectural state lives in this one block.

## Interface
Parameters:
- GPR_ADDR_WD, 5, GPR index width
- GPR_WD, 64, GPR data width
- CSR_ADDR_WD, 12, CSR address width
- CSR_WD, 64, CSR data width
- WS_TO_RF_BUS_WD, 147, must equal 2+GPR_ADDR_WD+GPR_WD+CSR_ADDR_WD+CSR_WD

Ports:
- i_clk  in  1  clock; single clock domain
- i_rst  in  1  synchronous, active-high reset
- i_ws_to_rf_bus  in  WS_TO_RF_BUS_WD  MSB→LSB: {gpr_wen, gpr_waddr, gpr_wdata, csr_wen, csr_waddr, csr_wdata}; all-zero when write-back is invalid
- i_raddr1, i_raddr2  in  GPR_ADDR_WD  GPR read addresses
- o_rdata1, o_rdata2  out  GPR_WD  GPR read data
- i_csr_raddr  in  CSR_ADDR_WD  CSR read address
- o_csr_rdata  out  CSR_WD  CSR read data
- i_ecall  in  1  trap entry strobe, one cycle
- i_ecall_pc  in  GPR_WD  PC of the trapping instruction
- i_mret  in  1  trap return strobe, one cycle
- o_mtvec  out  CSR_WD  current mtvec, for redirect
- o_mepc  out  CSR_WD  current mepc, for redirect

## Operation
- GPR file: 32 entries. x0 reads 0 and ignores writes. On posedge with gpr_wen=1 and waddr≠0: gpr[waddr] ← gpr_wdata.
- CSRs implemented: mstatus 0x300, mtvec 0x305, mepc 0x341, mcause 0x342. On posedge with csr_wen=1 and a matching address, the CSR ← csr_wdata. Writes to any other address are dropped. Reads of any other address return 0.
- ecall (i_ecall=1): mepc ← i_ecall_pc; mcause ← 11; mstatus.MPIE(bit7) ← MIE(bit3); MIE ← 0; MPP(bits12:11) ← 2'b11.
- mret (i_mret=1): MIE ← MPIE; MPIE ← 1; MPP ← 2'b00.
- Priority on the same cycle: a trap update to a field overrides a bus csr write to the same CSR. Bus write bits of mstatus not touched by the trap are also discarded that cycle. i_ecall and i_mret together: ecall wins and mret is ignored. A GPR write and a CSR write on the same cycle are independent and both commit.
- Read bypass: if gpr_wen=1, waddr≠0, and waddr==raddrN, then o_rdataN = gpr_wdata. If csr_wen=1 and csr_waddr==i_csr_raddr (implemented CSR), then o_csr_rdata = csr_wdata. Trap updates are not bypassed.
- o_mtvec and o_mepc show registered values only.

## Timing
- Reads and bypass are purely combinational, with zero latency. Writes become architecturally visible from the cycle after the edge.
- Reset (i_rst=1 at posedge): all GPRs 0; mstatus 64'h0000_000a_0000_1800; mtvec, mepc, mcause 0. Therefore o_mtvec=0, o_mepc=0, and o_rdata* read 0 from the first post-reset cycle.
- Reset dominates bus writes, ecall and mret on the same edge; nothing commits.
- Reset mid-stream: in-flight bus contents are discarded. The write-back stage re-drives the bus after reset.
- The bus has no handshake. The block accepts a write every cycle and never stalls.

## Structure
- Shared package ysyx_22050710_rf_pkg holds:
  - CSR address constants
  - MSTATUS_RESET
  - MCAUSE_ECALL_M = 11
  - mstatus bit positions (MIE, MPIE, MPP)
  - bus field offset/width localparams derived from the parameters, shared with the write-back unit packer
- Sub-module ysyx_22050710_gpr_file: the 32-entry array with x0 handling, one write port, two read ports and bypass.
- CSR storage, trap logic and bus unpacking stay in the top level. Expected size is about 200 lines.

## Test plan
- Reset, then read x0..x31 and all four CSRs → GPRs and mtvec/mepc/mcause read 0; mstatus reads 0xa00001800.
- Bus write x5←0xdead_beef, with i_raddr1=5 in the same cycle → o_rdata1=0xdead_beef (bypass), and it still reads 0xdead_beef on the next cycle. A write to x0 with 0x1234 → x0 reads 0 both in that cycle and the next.
- CSR write mtvec←0x8000_0100 → o_mtvec=0x8000_0100 the next cycle. A write to 0x7c0 → dropped; reading 0x7c0 returns 0.
- Set mstatus MIE=1, then pulse i_ecall with pc 0x8000_0040 → next cycle mepc=0x8000_0040, mcause=11, MIE=0, MPIE=1, MPP=3. Then pulse i_mret → MIE=1, MPIE=1, MPP=0.
- i_ecall together with a bus write mepc←0x1111 → mepc=i_ecall_pc. i_ecall with i_mret → only the ecall effects apply.
- Assert i_rst while the bus carries a write to x7 and a csr_wen to mepc → x7 and mepc read 0 after the edge.
